// File: rtl/clk_div_sched.sv
// Round-robin scheduler sharing one programmable clock-enable divider among N_REQ requesters.
// Grants change only on full divided-period boundaries, so every emitted period is complete.
module clk_div_sched #(
   parameter int N_REQ      = 4,
   parameter int DIV_W      = 31,
   parameter int HOLD_TICKS = 16
) (
   input  logic                   clk_100MHz,
   input  logic                   rst,
   input  logic [N_REQ-1:0]       req,
   input  logic [N_REQ*DIV_W-1:0] div_ratio,
   output logic [N_REQ-1:0]       grant,
   output logic [DIV_W-1:0]       div_active,
   output logic                   tick,
   output logic                   clk_sq,
   output logic                   busy
);
   localparam int IDX_W  = $clog2(N_REQ);
   localparam int HOLD_W = $clog2(HOLD_TICKS + 1);
   localparam logic [HOLD_W-1:0] HOLD_MAX  = HOLD_W'(HOLD_TICKS);
   localparam logic [DIV_W-1:0]  MIN_RATIO = DIV_W'(2);

   typedef enum logic [1:0] {S_IDLE, S_ARB, S_RUN, S_DRAIN} state_e;

   // Handshake: req is a level request with no acknowledge; a requester owns the divider
   // while its grant bit is high and keeps it only as long as it holds req.
   state_e              state_q, state_d;
   logic [IDX_W-1:0]    last_q, last_d;
   logic [IDX_W-1:0]    win_q, win_d;
   logic [DIV_W-1:0]    ratio_q, ratio_d;
   logic [DIV_W-1:0]    cnt_q, cnt_d;
   logic [HOLD_W-1:0]   hold_q, hold_d;
   logic [N_REQ-1:0]    grant_q, grant_d;
   logic [DIV_W-1:0]    div_active_q, div_active_d;
   logic                clk_sq_q, clk_sq_d;

   logic                rr_found;
   logic [IDX_W-1:0]    rr_pick;
   logic [DIV_W-1:0]    pick_ratio;
   logic                period_end;
   logic [HOLD_W-1:0]   hold_inc;
   logic [DIV_W:0]      half_d;

   // Search starts one past the last owner and wraps, giving strict rotation.
   always_comb begin
      rr_found = 1'b0;
      rr_pick  = '0;
      for (int k = 1; k <= N_REQ; k++) begin
         if (!rr_found && req[IDX_W'((int'(last_q) + k) % N_REQ)]) begin
            rr_found = 1'b1;
            rr_pick  = IDX_W'((int'(last_q) + k) % N_REQ);
         end
      end
      pick_ratio = '0;
      for (int i = 0; i < N_REQ; i++) begin
         if (rr_pick == IDX_W'(i)) pick_ratio = div_ratio[i*DIV_W +: DIV_W];
      end
   end

   always_comb begin
      state_d    = state_q;
      last_d     = last_q;
      win_d      = win_q;
      ratio_d    = ratio_q;
      cnt_d      = cnt_q;
      hold_d     = hold_q;
      period_end = (state_q == S_RUN) && (cnt_q == ratio_q - DIV_W'(1));
      hold_inc   = (hold_q == HOLD_MAX) ? hold_q : hold_q + HOLD_W'(1);

      case (state_q)
         S_IDLE: begin
            if (|req) state_d = S_ARB;
         end
         S_ARB: begin
            if (rr_found) begin
               win_d   = rr_pick;
               ratio_d = (pick_ratio < MIN_RATIO) ? MIN_RATIO : pick_ratio;
               cnt_d   = '0;
               hold_d  = '0;
               state_d = S_RUN;
            end else begin
               state_d = S_IDLE;
            end
         end
         S_RUN: begin
            if (period_end) begin
               cnt_d  = '0;
               hold_d = hold_inc;
               if (!(|(req & grant_q)) || ((hold_inc == HOLD_MAX) && (|(req & ~grant_q))))
                  state_d = S_DRAIN;
            end else begin
               cnt_d = cnt_q + DIV_W'(1);
            end
         end
         S_DRAIN: begin
            last_d  = win_q;
            state_d = (|req) ? S_ARB : S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase

      // Registered outputs are derived from the next state so they align with cnt.
      grant_d      = '0;
      div_active_d = '0;
      clk_sq_d     = 1'b0;
      half_d       = ({1'b0, ratio_d} + {{DIV_W{1'b0}}, 1'b1}) >> 1;
      if (state_d == S_RUN) begin
         for (int i = 0; i < N_REQ; i++) grant_d[i] = (win_d == IDX_W'(i));
         div_active_d = ratio_d;
         clk_sq_d     = ({1'b0, cnt_d} < half_d);
      end
   end

   always_ff @(posedge clk_100MHz) begin
      if (rst) begin
         state_q      <= S_IDLE;
         last_q       <= IDX_W'(N_REQ - 1);
         win_q        <= '0;
         ratio_q      <= '0;
         cnt_q        <= '0;
         hold_q       <= '0;
         grant_q      <= '0;
         div_active_q <= '0;
         clk_sq_q     <= 1'b0;
      end else begin
         state_q      <= state_d;
         last_q       <= last_d;
         win_q        <= win_d;
         ratio_q      <= ratio_d;
         cnt_q        <= cnt_d;
         hold_q       <= hold_d;
         grant_q      <= grant_d;
         div_active_q <= div_active_d;
         clk_sq_q     <= clk_sq_d;
      end
   end

   assign grant      = grant_q;
   assign div_active = div_active_q;
   assign clk_sq     = clk_sq_q;
   assign tick       = period_end;
   assign busy       = (state_q != S_IDLE);

endmodule

// File: tb/tb_clk_div_sched.sv
// Bench for clk_div_sched: directed scenarios plus random traffic, every cycle compared
// against a grant/period-position reference model.
module tb_clk_div_sched;
   localparam int N_REQ      = 4;
   localparam int DIV_W      = 31;
   localparam int HOLD_TICKS = 16;

   logic                   clk_100MHz = 1'b0;
   logic                   rst;
   logic [N_REQ-1:0]       req;
   logic [N_REQ*DIV_W-1:0] div_ratio;
   logic [N_REQ-1:0]       grant;
   logic [DIV_W-1:0]       div_active;
   logic                   tick;
   logic                   clk_sq;
   logic                   busy;

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model: who owns the divider, where in the period it is, periods completed.
   int m_owner;
   int m_pos;
   int m_periods;
   int m_ptr;
   int m_ratio;
   bit m_arb;
   bit m_drain;

   logic [N_REQ-1:0] exp_q[$];

   always #5 clk_100MHz = ~clk_100MHz;

   clk_div_sched #(
      .N_REQ(N_REQ),
      .DIV_W(DIV_W),
      .HOLD_TICKS(HOLD_TICKS)
   ) dut (
      .clk_100MHz(clk_100MHz),
      .rst(rst),
      .req(req),
      .div_ratio(div_ratio),
      .grant(grant),
      .div_active(div_active),
      .tick(tick),
      .clk_sq(clk_sq),
      .busy(busy)
   );

   function automatic int clamp_ratio(input logic [DIV_W-1:0] v);
      return (v < 2) ? 2 : int'(v);
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_checks++;
      assert (obs === expv) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h at %0t", tag, obs, expv, $time);
      end
   endtask

   task automatic set_ratio(input int idx, input int val);
      div_ratio[idx*DIV_W +: DIV_W] = DIV_W'(val);
   endtask

   task automatic model_step();
      if (rst) begin
         m_owner = -1; m_pos = 0; m_periods = 0; m_ptr = N_REQ - 1;
         m_ratio = 0;  m_arb = 1'b0; m_drain = 1'b0;
      end else if (m_owner >= 0) begin
         if (m_pos == m_ratio - 1) begin
            m_periods++;
            if (!req[m_owner] ||
                (m_periods >= HOLD_TICKS && (req & ~(N_REQ'(1) << m_owner)) != 0)) begin
               m_ptr   = m_owner;
               m_owner = -1;
               m_drain = 1'b1;
            end else begin
               m_pos = 0;
            end
         end else begin
            m_pos++;
         end
      end else if (m_drain) begin
         m_drain = 1'b0;
         m_arb   = (req != 0);
      end else if (m_arb) begin
         m_arb = 1'b0;
         for (int k = 1; k <= N_REQ; k++) begin
            int c = (m_ptr + k) % N_REQ;
            if (m_owner < 0 && req[c]) m_owner = c;
         end
         if (m_owner >= 0) begin
            m_ratio   = clamp_ratio(div_ratio[m_owner*DIV_W +: DIV_W]);
            m_pos     = 0;
            m_periods = 0;
         end
      end else if (req != 0) begin
         m_arb = 1'b1;
      end
   endtask

   task automatic cycle();
      logic [31:0] e_grant, e_div, e_tick, e_sq, e_busy;
      @(posedge clk_100MHz);
      model_step();
      #1;
      e_grant = (m_owner >= 0) ? (32'd1 << m_owner) : 32'd0;
      e_div   = (m_owner >= 0) ? 32'(m_ratio) : 32'd0;
      e_tick  = 32'((m_owner >= 0) && (m_pos == m_ratio - 1));
      e_sq    = 32'((m_owner >= 0) && (m_pos < (m_ratio + 1) / 2));
      e_busy  = 32'((m_owner >= 0) || m_arb || m_drain);
      chk("grant", 32'(grant), e_grant);
      chk("div_active", 32'(div_active), e_div);
      chk("tick", 32'(tick), e_tick);
      chk("clk_sq", 32'(clk_sq), e_sq);
      chk("busy", 32'(busy), e_busy);
   endtask

   task automatic run_count(input int n, output int ticks, output int highs);
      ticks = 0;
      highs = 0;
      for (int i = 0; i < n; i++) begin
         cycle();
         if (tick === 1'b1) ticks++;
         if (clk_sq === 1'b1) highs++;
      end
   endtask

   task automatic release_all(input int n);
      req = '0;
      for (int i = 0; i < n; i++) cycle();
   endtask

   initial begin
      int t_cnt, h_cnt;
      logic [N_REQ-1:0] prev;

      rst = 1'b1;
      req = '0;
      div_ratio = '0;
      m_owner = -1; m_pos = 0; m_periods = 0; m_ptr = N_REQ - 1;
      m_ratio = 0;  m_arb = 1'b0; m_drain = 1'b0;

      // Reset state
      repeat (3) cycle();
      chk("rst_grant", 32'(grant), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      rst = 1'b0;
      cycle();

      // Single requester, ratio 4
      set_ratio(0, 4);
      req = 4'b0001;
      repeat (2) cycle();
      chk("lat_grant", 32'(grant), 32'h1);
      chk("lat_clk_sq", 32'(clk_sq), 32'd1);
      run_count(16, t_cnt, h_cnt);
      chk("r4_ticks", 32'(t_cnt), 32'd4);
      chk("r4_high", 32'(h_cnt), 32'd8);
      release_all(16);

      // Odd ratio 5
      set_ratio(0, 5);
      req = 4'b0001;
      repeat (2) cycle();
      run_count(20, t_cnt, h_cnt);
      chk("r5_ticks", 32'(t_cnt), 32'd4);
      chk("r5_high", 32'(h_cnt), 32'd12);
      release_all(16);

      // Clamped ratios 0 and 1
      for (int r = 0; r < 2; r++) begin
         set_ratio(0, r);
         req = 4'b0001;
         repeat (2) cycle();
         chk("clamp_div", 32'(div_active), 32'd2);
         run_count(8, t_cnt, h_cnt);
         chk("clamp_ticks", 32'(t_cnt), 32'd4);
         release_all(8);
      end

      // Pre-emption after HOLD_TICKS periods
      set_ratio(0, 3);
      set_ratio(2, 2);
      req = 4'b0001;
      repeat (2) cycle();
      t_cnt = 0;
      for (int i = 0; i < 100 && t_cnt < 5; i++) begin
         cycle();
         if (tick === 1'b1) t_cnt++;
      end
      req = 4'b0101;
      for (int i = 0; i < 200 && t_cnt < 16; i++) begin
         cycle();
         if (tick === 1'b1) t_cnt++;
      end
      chk("pre_ticks", 32'(t_cnt), 32'd16);
      chk("pre_hold", 32'(grant), 32'h1);
      repeat (3) cycle();
      chk("pre_grant", 32'(grant), 32'h4);
      release_all(16);

      // Mid-period release, ratio 10
      set_ratio(0, 10);
      req = 4'b0001;
      repeat (3) cycle();
      req = '0;
      run_count(8, t_cnt, h_cnt);
      chk("mid_ticks", 32'(t_cnt), 32'd1);
      chk("mid_last_tick", 32'(tick), 32'd1);
      repeat (2) cycle();
      chk("mid_busy", 32'(busy), 32'd0);

      // Round-robin fairness from reset
      rst = 1'b1;
      cycle();
      rst = 1'b0;
      for (int i = 0; i < N_REQ; i++) set_ratio(i, 2);
      exp_q = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
      prev = '0;
      req = 4'b1111;
      for (int i = 0; i < 400 && exp_q.size() > 0; i++) begin
         cycle();
         if (grant !== '0 && grant !== prev) begin
            chk("rr_order", 32'(grant), 32'(exp_q.pop_front()));
            prev = grant;
         end
      end
      chk("rr_done", 32'(exp_q.size()), 32'd0);

      // Reset mid-RUN
      rst = 1'b1;
      cycle();
      rst = 1'b0;
      set_ratio(0, 8);
      repeat (2) cycle();
      repeat (3) cycle();
      rst = 1'b1;
      cycle();
      chk("rrun_grant", 32'(grant), 32'd0);
      chk("rrun_div", 32'(div_active), 32'd0);
      chk("rrun_clk_sq", 32'(clk_sq), 32'd0);
      chk("rrun_busy", 32'(busy), 32'd0);
      rst = 1'b0;
      repeat (2) cycle();
      chk("rrun_regrant", 32'(grant), 32'h1);

      // Random traffic
      for (int n = 0; n < 3000; n++) begin
         if ($urandom_range(0, 5) == 0) req = N_REQ'($urandom_range(0, (1 << N_REQ) - 1));
         if ($urandom_range(0, 19) == 0)
            set_ratio(int'($urandom_range(0, N_REQ - 1)), int'($urandom_range(0, 7)));
         rst = ($urandom_range(0, 999) == 0);
         cycle();
      end
      rst = 1'b0;

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
